boot_loader: RTL and testbench

Loads a program image from a byte stream into the processor's instruction memory, then releases the processor to run. It sits directly upstream of the single-cycle MIPS core:
- it drives the instruction-memory write port;
- it holds the core in reset (`cpu_run` = 0) until a complete, checksum-verified image has been written.

---
 rtl/boot_loader_if.sv | 20 ++
 rtl/boot_loader.sv | 162 ++++++++++++++++
 tb/tb_boot_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// Byte-stream and instruction-memory write signals of the boot loader.
// master = loader side, slave = stream source / instruction memory side.
interface boot_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/boot_loader.sv
// Loads a counted, checksummed big-endian word image into instruction memory,
// then releases the processor from reset.
module boot_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          Reset,
    input  logic          start,
    boot_loader_if.master bus,
    output logic          cpu_run,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int unsigned IDX_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t state, state_nxt;

    logic [15:0]      len;
    logic [15:0]      len_full;
    logic [23:0]      asm_q;
    logic [1:0]       byte_cnt;
    logic [IDX_W-1:0] index;
    logic [7:0]       csum;

    logic accept;
    logic oversize;
    logic last_word;
    logic start_ok;

    logic rx_ready_nxt;
    logic busy_nxt;
    logic cpu_run_nxt;
    logic err_nxt;
    logic done_nxt;
    logic wr_nxt;

    always_comb begin
        accept    = bus.rx_valid & bus.rx_ready;
        start_ok  = start & ((state == S_IDLE) | (state == S_ERROR));
        len_full  = {len[15:8], bus.rx_data};
        oversize  = 32'(len_full) > (32'd1 << ADDR_W);
        last_word = (byte_cnt == 2'd3) && ((32'(index) + 32'd1) == 32'(len));
    end

    // State register
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERROR: begin
                if (start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (oversize)             state_nxt = S_ERROR;
                    else if (len_full == '0)  state_nxt = S_CHECK;
                    else                      state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && last_word) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (accept) state_nxt = (bus.rx_data == csum) ? S_RUN : S_ERROR;
            end
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        rx_ready_nxt = 1'b0;
        busy_nxt     = 1'b0;
        cpu_run_nxt  = 1'b0;
        err_nxt      = 1'b0;
        case (state_nxt)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: begin
                rx_ready_nxt = 1'b1;
                busy_nxt     = 1'b1;
            end
            S_RUN:   cpu_run_nxt = 1'b1;
            S_ERROR: err_nxt     = 1'b1;
            default: ;
        endcase
        done_nxt = (state == S_CHECK) && accept && (bus.rx_data == csum);
        wr_nxt   = (state == S_DATA) && accept && (byte_cnt == 2'd3);
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            bus.rx_ready <= 1'b0;
            busy         <= 1'b0;
            cpu_run      <= 1'b0;
            err          <= 1'b0;
            done         <= 1'b0;
        end else begin
            bus.rx_ready <= rx_ready_nxt;
            busy         <= busy_nxt;
            cpu_run      <= cpu_run_nxt;
            err          <= err_nxt;
            done         <= done_nxt;
        end
    end

    // Datapath: the write register is loaded straight from the assembly
    // register plus the 4th byte, so the stream never has to stall.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            len            <= '0;
            asm_q          <= '0;
            byte_cnt       <= '0;
            index          <= '0;
            csum           <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE;
            bus.imem_wdata <= '0;
        end else begin
            bus.imem_we <= wr_nxt;
            if (start_ok) begin
                csum     <= '0;
                byte_cnt <= '0;
                index    <= '0;
            end
            if (accept && (state == S_LEN_HI)) len[15:8] <= bus.rx_data;
            if (accept && (state == S_LEN_LO)) len[7:0]  <= bus.rx_data;
            if (accept && (state == S_DATA)) begin
                asm_q    <= {asm_q[15:0], bus.rx_data};
                csum     <= csum + bus.rx_data;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (wr_nxt) begin
                bus.imem_wdata <= {asm_q, bus.rx_data};
                bus.imem_addr  <= BASE + 32'({index, 2'b00});
                index          <= index + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: table of image loads plus hand-written
// corner sequences; memory writes are checked against a scoreboard queue.
module tb_boot_loader;
    localparam int unsigned ADDR_W = 8;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic clock = 1'b0;
    logic Reset;
    logic start;
    logic cpu_run, busy, done, err;

    boot_loader_if bus ();

    boot_loader #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
        .clock   (clock),
        .Reset   (Reset),
        .start   (start),
        .bus     (bus),
        .cpu_run (cpu_run),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        int              n;
        logic [3:0][31:0] w;
        bit              bad_cs;
        bit              gap;
        bit              pre_reset;
        bit              exp_run;
        bit              exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clock) begin
        if (bus.imem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr %h data %h expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.imem_addr, bus.imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got addr %h data %h expected addr %h data %h",
                             bus.imem_addr, bus.imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic do_reset();
        Reset = 1'b0;
        start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (2) @(posedge clock);
        #1 Reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok;
        if (gap) begin
            while ($urandom_range(0, 1) == 1) begin
                bus.rx_valid = 1'b0;
                @(posedge clock);
                #1;
            end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 50; i++) begin
            ok = bus.rx_ready;
            @(posedge clock);
            #1;
            if (ok) begin
                bus.rx_valid = 1'b0;
                return;
            end
        end
        bus.rx_valid = 1'b0;
        check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input bit gap,
                             inout logic [7:0] cs);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = w[31 - 8*k -: 8];
            cs = cs + b;
            if (k == 3) exp_q.push_back({BASE + 32'(idx) * 32'd4, w});
            send_byte(b, gap);
        end
    endtask

    task automatic load(input int n, input logic [31:0] w[$], input bit bad_cs,
                        input bit gap, input bit exp_run, input bit exp_err,
                        input string tag);
        logic [7:0]  cs;
        logic [15:0] nn;
        cs = '0;
        nn = 16'(n);
        pulse_start();
        check({tag, "_ready_after_start"}, 32'(bus.rx_ready), 32'd1);
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_err_cleared"}, 32'(err), 32'd0);
        send_byte(nn[15:8], gap);
        send_byte(nn[7:0], gap);
        for (int i = 0; i < n; i++) send_word(w[i], i, gap, cs);
        check({tag, "_run_before_cs"}, 32'(cpu_run), 32'd0);
        send_byte(bad_cs ? 8'h00 : cs, gap);
        check({tag, "_cpu_run"}, 32'(cpu_run), 32'(exp_run));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_done"}, 32'(done), 32'(exp_run));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_ready_end"}, 32'(bus.rx_ready), 32'd0);
        check({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_cpu_run_hold"}, 32'(cpu_run), 32'(exp_run));
    endtask

    localparam logic [31:0] W0 = 32'h2008_0005;
    localparam logic [31:0] W1 = 32'h0109_5020;

    vec_t vecs[5];
    logic [31:0] wq[$];

    initial begin
        vecs[0] = '{n: 2, w: {32'h0, 32'h0, W1, W0}, bad_cs: 0, gap: 0, pre_reset: 1, exp_run: 1, exp_err: 0};
        vecs[1] = '{n: 2, w: {32'h0, 32'h0, W1, W0}, bad_cs: 1, gap: 0, pre_reset: 1, exp_run: 0, exp_err: 1};
        vecs[2] = '{n: 2, w: {32'h0, 32'h0, W1, W0}, bad_cs: 0, gap: 1, pre_reset: 0, exp_run: 1, exp_err: 0};
        vecs[3] = '{n: 0, w: '0, bad_cs: 0, gap: 0, pre_reset: 1, exp_run: 1, exp_err: 0};
        vecs[4] = '{n: 4, w: {32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1234_5678},
                    bad_cs: 0, gap: 1, pre_reset: 1, exp_run: 1, exp_err: 0};

        do_reset();
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_imem_addr", bus.imem_addr, BASE);
        check("rst_imem_wdata", bus.imem_wdata, 32'd0);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].pre_reset) do_reset();
            wq.delete();
            for (int i = 0; i < vecs[v].n; i++) wq.push_back(vecs[v].w[i]);
            load(vecs[v].n, wq, vecs[v].bad_cs, vecs[v].gap, vecs[v].exp_run,
                 vecs[v].exp_err, $sformatf("vec%0d", v));
        end

        // Oversize count: 257 words with ADDR_W=8
        do_reset();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("big_err", 32'(err), 32'd1);
        check("big_ready", 32'(bus.rx_ready), 32'd0);
        check("big_busy", 32'(busy), 32'd0);
        check("big_cpu_run", 32'(cpu_run), 32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        repeat (4) @(posedge clock);
        #1 bus.rx_valid = 1'b0;
        check("big_err_sticky", 32'(err), 32'd1);

        // Largest legal count fills the whole memory
        do_reset();
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back(32'(i) * 32'h0101_0101 + 32'h0001_0203);
        load(256, wq, 0, 0, 1, 0, "full");

        // Reset in the middle of word 3 of a 4-word load
        do_reset();
        begin
            logic [7:0] cs;
            cs = '0;
            pulse_start();
            send_byte(8'h00, 0);
            send_byte(8'h04, 0);
            send_word(32'h1111_2222, 0, 0, cs);
            send_word(32'h3333_4444, 1, 0, cs);
            send_byte(8'h55, 0);
            send_byte(8'h66, 0);
        end
        #2 Reset = 1'b0;
        #1;
        check("abort_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("abort_imem_we", 32'(bus.imem_we), 32'd0);
        check("abort_imem_addr", bus.imem_addr, BASE);
        check("abort_imem_wdata", bus.imem_wdata, 32'd0);
        check("abort_cpu_run", 32'(cpu_run), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_writes_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1 Reset = 1'b1;
        @(posedge clock);
        #1;
        wq.delete();
        wq.push_back(32'hCAFE_0001);
        wq.push_back(32'hCAFE_0002);
        wq.push_back(32'hCAFE_0003);
        load(3, wq, 0, 0, 1, 0, "reload");

        // RUN ignores start and stream bytes
        start = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h00;
        @(posedge clock);
        #1 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("run_ready", 32'(bus.rx_ready), 32'd0);
            check("run_cpu_run", 32'(cpu_run), 32'd1);
            check("run_busy", 32'(busy), 32'd0);
            check("run_done", 32'(done), 32'd0);
            @(posedge clock);
            #1;
        end
        bus.rx_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end
endmodule
